// File: rtl/bus_pkg.sv
// bus_pkg: types and helpers shared by the serial link.
//   serial_frame_t : 27-bit frame sent MSB-first. Field order is
//                    start, cmd, addr, data, parity, stop.
//   cmd_t          : bus command encoding.
//   deser_state_e  : receiver FSM states.
//   calc_parity    : even parity over {cmd, addr, data}.
//   sat_inc16      : 16-bit increment that holds at 16'hFFFF.
package bus_pkg;

   localparam int FRAME_BITS = 27;
   localparam int SCLK_DIV   = 4;

   typedef enum logic [1:0] {
      CMD_READ  = 2'b00,
      CMD_WRITE = 2'b01
   } cmd_t;

   typedef struct packed {
      logic        start;
      cmd_t        cmd;
      logic [13:0] addr;
      logic [7:0]  data;
      logic        parity;
      logic        stop;
   } serial_frame_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } deser_state_e;

   function automatic logic calc_parity(input cmd_t cmd, input logic [13:0] addr,
                                        input logic [7:0] data);
      return ^{cmd, addr, data};
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/deserializer_line_sync.sv
// line_sync: multi-flop synchroniser with rising-edge detect.
//   clk_i  : system clock
//   rst_ni : async active-low reset, all flops clear to 0
//   d_i    : asynchronous input line
//   q_o    : synchronised level (SYNC_STAGES flops deep)
//   rise_o : high for one cycle when q_o goes 0 -> 1
module line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign q_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/deserializer.sv
// deserializer: samples sdata on synchronised sclk rising edges, rebuilds a
// serial_frame_t, checks start/parity/stop and offers it on valid/ready.
//   clk_i, rst_ni        : clock, async active-low reset
//   sdata_i, sclk_i      : serial line (idles low), data sampled on sclk rise
//   frame_o, valid_o     : last accepted frame / unconsumed-frame flag
//   ready_i              : consumer handshake
//   busy_o               : frame in progress (SHIFT or CHECK)
//   parity_err_o, frame_err_o, overrun_o : one-cycle error pulses
// Optional build macro DESER_ERR_CNT_EN adds saturating 16-bit counters
//   parity_err_cnt_o, frame_err_cnt_o, overrun_cnt_o.
//
// state | meaning
// IDLE  | waiting for an sclk rise with sdata = 1 (start bit)
// SHIFT | collecting bits, inter-edge timeout running
// CHECK | one cycle: validate stop/parity, accept or drop the frame
module deserializer
   import bus_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          sdata_i,
   input  logic          sclk_i,
   output serial_frame_t frame_o,
   output logic          valid_o,
   input  logic          ready_i,
   output logic          busy_o,
   output logic          parity_err_o,
   output logic          frame_err_o,
   output logic          overrun_o
`ifdef DESER_ERR_CNT_EN
  ,output logic [15:0]   parity_err_cnt_o,
   output logic [15:0]   frame_err_cnt_o,
   output logic [15:0]   overrun_cnt_o
`endif
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   // Loaded on the edge after a detected rise; reaching zero and then
   // registering the pulse puts frame_err_o exactly TIMEOUT_CYCLES cycles
   // after the cycle in which the last rise was seen.
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 2);

   logic sdata_s, sclk_rise, sdata_rise_unused, sclk_s_unused;

   line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk_i (clk_i), .rst_ni(rst_ni), .d_i(sclk_i),
      .q_o   (sclk_s_unused), .rise_o(sclk_rise)
   );

   line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
      .clk_i (clk_i), .rst_ni(rst_ni), .d_i(sdata_i),
      .q_o   (sdata_s), .rise_o(sdata_rise_unused)
   );

   deser_state_e          state_q, state_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [4:0]            bit_cnt_q, bit_cnt_d;
   logic [TMR_W-1:0]      tmr_q, tmr_d;
   serial_frame_t         frame_q, frame_d, frame_c;
   logic                  valid_q, valid_d;
   logic                  par_q, par_d, frm_q, frm_d, ovr_q, ovr_d;

   assign frame_c = serial_frame_t'(shreg_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         tmr_q     <= '0;
         frame_q   <= '0;
         valid_q   <= 1'b0;
         par_q     <= 1'b0;
         frm_q     <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         tmr_q     <= tmr_d;
         frame_q   <= frame_d;
         valid_q   <= valid_d;
         par_q     <= par_d;
         frm_q     <= frm_d;
         ovr_q     <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      tmr_d     = tmr_q;
      frame_d   = frame_q;
      valid_d   = valid_q & ~ready_i;
      par_d     = 1'b0;
      frm_d     = 1'b0;
      ovr_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (sclk_rise && sdata_s) begin
               shreg_d   = {{(FRAME_BITS-1){1'b0}}, 1'b1};
               bit_cnt_d = 5'd1;
               tmr_d     = TMR_LOAD;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (sclk_rise) begin
               shreg_d   = {shreg_q[FRAME_BITS-2:0], sdata_s};
               bit_cnt_d = bit_cnt_q + 5'd1;
               tmr_d     = TMR_LOAD;
               if (bit_cnt_q == 5'(FRAME_BITS - 1)) state_d = CHECK;
            end else if (tmr_q == '0) begin
               frm_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         CHECK: begin
            state_d = IDLE;
            // Stop error masks parity; a held frame that is consumed this
            // same cycle is not an overrun.
            if (!frame_c.stop || !frame_c.start) begin
               frm_d = 1'b1;
            end else if (frame_c.parity != calc_parity(frame_c.cmd, frame_c.addr, frame_c.data)) begin
               par_d = 1'b1;
            end else if (valid_q && !ready_i) begin
               ovr_d = 1'b1;
            end else begin
               frame_d = frame_c;
               valid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign frame_o      = frame_q;
   assign valid_o      = valid_q;
   assign busy_o       = (state_q != IDLE);
   assign parity_err_o = par_q;
   assign frame_err_o  = frm_q;
   assign overrun_o    = ovr_q;

`ifdef DESER_ERR_CNT_EN
   logic [15:0] par_cnt_q, frm_cnt_q, ovr_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         par_cnt_q <= '0;
         frm_cnt_q <= '0;
         ovr_cnt_q <= '0;
      end else begin
         if (par_q) par_cnt_q <= sat_inc16(par_cnt_q);
         if (frm_q) frm_cnt_q <= sat_inc16(frm_cnt_q);
         if (ovr_q) ovr_cnt_q <= sat_inc16(ovr_cnt_q);
      end
   end

   assign parity_err_cnt_o = par_cnt_q;
   assign frame_err_cnt_o  = frm_cnt_q;
   assign overrun_cnt_o    = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;
   import bus_pkg::*;

   localparam int SYNC    = 2;
   localparam int TIMEOUT = 64;
   localparam int LAT     = SYNC + 2;
   // Hand-computed frames: WR parity = popcount(01,1234,AB)=11 -> 1,
   // RD parity = popcount(00,0100,00)=1 -> 1.
   localparam logic [26:0] WR = {1'b1, 2'b01, 14'h1234, 8'hAB, 1'b1, 1'b1};
   localparam logic [26:0] RD = {1'b1, 2'b00, 14'h0100, 8'h00, 1'b1, 1'b1};

   logic clk = 1'b0;
   logic rst_ni, sdata, sclk, ready;
   serial_frame_t frame_o;
   logic valid_o, busy_o, parity_err_o, frame_err_o, overrun_o;
`ifdef DESER_ERR_CNT_EN
   logic [15:0] par_cnt, frm_cnt, ovr_cnt;
`endif

   deserializer #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .sdata_i(sdata), .sclk_i(sclk),
      .frame_o(frame_o), .valid_o(valid_o), .ready_i(ready), .busy_o(busy_o),
      .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o)
`ifdef DESER_ERR_CNT_EN
     ,.parity_err_cnt_o(par_cnt), .frame_err_cnt_o(frm_cnt), .overrun_cnt_o(ovr_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0, par_tot = 0, frm_tot = 0, ovr_tot = 0, valid_hi = 0, frm_last_cyc = 0;
   int n_chk = 0, n_err = 0, last_rise_cyc = 0;
   int par_base = 0, frm_base = 0, ovr_base = 0;

   always begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (parity_err_o) par_tot = par_tot + 1;
      if (frame_err_o) begin frm_tot = frm_tot + 1; frm_last_cyc = cyc; end
      if (overrun_o) ovr_tot = ovr_tot + 1;
      if (valid_o) valid_hi = valid_hi + 1;
   end

   task automatic drive_bit(input logic b);
      @(negedge clk) sdata = b;
      repeat (SCLK_DIV - 1) @(negedge clk);
      sclk = 1'b1;
      last_rise_cyc = cyc;
      repeat (SCLK_DIV) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic send_bits(input logic [26:0] f, input int n);
      for (int i = 0; i < n; i++) drive_bit(f[26-i]);
   endtask

   // Leaves sclk high on return; caller lowers it.
   task automatic raise_stop(input logic b);
      @(negedge clk) sdata = b;
      repeat (SCLK_DIV - 1) @(negedge clk);
      sclk = 1'b1;
      last_rise_cyc = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_ni = 1'b0; sdata = 1'b0; sclk = 1'b0; ready = 1'b1;
      idle(3); #1;
      n_chk++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
      n_chk++; if (frame_o !== 27'h0) begin n_err++; $display("FAIL reset_frame: got %h want 0", frame_o); end
      n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      n_chk++; if ({parity_err_o, frame_err_o, overrun_o} !== 3'b000) begin n_err++;
         $display("FAIL reset_errs: got %b want 000", {parity_err_o, frame_err_o, overrun_o}); end
      @(negedge clk) rst_ni = 1'b1;
      idle(5);
      n_chk++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin n_err++;
         $display("FAIL post_reset_idle: busy=%b valid=%b want 0 0", busy_o, valid_o); end
   endtask

   task automatic test_write;
      int p0, f0, o0, v0;
      p0 = par_tot; f0 = frm_tot; o0 = ovr_tot; v0 = valid_hi;
      ready = 1'b1;
      send_bits(WR, 27);
      idle(10);
      n_chk++; if (frame_o !== WR) begin n_err++; $display("FAIL write_frame: got %h want %h", frame_o, WR); end
      n_chk++; if (valid_hi - v0 != 1) begin n_err++; $display("FAIL write_valid_cycles: got %0d want 1", valid_hi - v0); end
      n_chk++; if (par_tot + frm_tot + ovr_tot - p0 - f0 - o0 != 0) begin n_err++;
         $display("FAIL write_no_errs: got %0d pulses want 0", par_tot + frm_tot + ovr_tot - p0 - f0 - o0); end
   endtask

   task automatic test_read;
      int v0, first;
      logic b3, b4;
      v0 = valid_hi; first = 0; b3 = 1'b0; b4 = 1'b1;
      ready = 1'b1;
      drive_bit(RD[26]);
      n_chk++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL read_busy_start: got %b want 1", busy_o); end
      for (int i = 1; i < 26; i++) drive_bit(RD[26-i]);
      raise_stop(RD[0]);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (valid_o && first == 0) first = k;
         if (k == LAT - 1) b3 = busy_o;
         if (k == LAT) b4 = busy_o;
      end
      @(negedge clk) sclk = 1'b0;
      idle(5);
      n_chk++; if (first != LAT) begin n_err++; $display("FAIL read_latency: got %0d want %0d", first, LAT); end
      n_chk++; if (b3 !== 1'b1) begin n_err++; $display("FAIL read_busy_check: got %b want 1", b3); end
      n_chk++; if (b4 !== 1'b0) begin n_err++; $display("FAIL read_busy_after: got %b want 0", b4); end
      n_chk++; if (frame_o !== RD) begin n_err++; $display("FAIL read_frame: got %h want %h", frame_o, RD); end
      n_chk++; if (valid_hi - v0 != 1) begin n_err++; $display("FAIL read_valid_cycles: got %0d want 1", valid_hi - v0); end
   endtask

   task automatic test_parity_err;
      int p0, f0, v0;
      logic [26:0] bad;
      bad = WR ^ 27'h2;
      p0 = par_tot; f0 = frm_tot; v0 = valid_hi;
      send_bits(bad, 27);
      idle(10);
      n_chk++; if (par_tot - p0 != 1) begin n_err++; $display("FAIL parity_pulse: got %0d want 1", par_tot - p0); end
      n_chk++; if (valid_hi - v0 != 0) begin n_err++; $display("FAIL parity_valid: got %0d want 0", valid_hi - v0); end
      n_chk++; if (frame_o !== RD) begin n_err++; $display("FAIL parity_frame_held: got %h want %h", frame_o, RD); end
      n_chk++; if (frm_tot - f0 != 0) begin n_err++; $display("FAIL parity_no_frmerr: got %0d want 0", frm_tot - f0); end
   endtask

   task automatic test_stop_err;
      int p0, f0, v0;
      logic [26:0] bad;
      bad = WR & ~27'h1;
      p0 = par_tot; f0 = frm_tot; v0 = valid_hi;
      send_bits(bad, 27);
      idle(10);
      n_chk++; if (frm_tot - f0 != 1) begin n_err++; $display("FAIL stop_pulse: got %0d want 1", frm_tot - f0); end
      n_chk++; if (par_tot - p0 != 0) begin n_err++; $display("FAIL stop_no_parity: got %0d want 0", par_tot - p0); end
      n_chk++; if (valid_hi - v0 != 0) begin n_err++; $display("FAIL stop_valid: got %0d want 0", valid_hi - v0); end
   endtask

   task automatic test_timeout;
      int f0, v0, t_rise, waited;
      f0 = frm_tot;
      send_bits(WR, 10);
      t_rise = last_rise_cyc;
      waited = 0;
      while (frm_tot == f0 && waited < 300) begin @(negedge clk); waited++; end
      n_chk++; if (frm_tot - f0 != 1) begin n_err++; $display("FAIL timeout_pulse: got %0d want 1", frm_tot - f0); end
      n_chk++; if (frm_last_cyc - t_rise != SYNC + TIMEOUT) begin n_err++;
         $display("FAIL timeout_delay: got %0d want %0d", frm_last_cyc - t_rise, SYNC + TIMEOUT); end
      idle(3);
      n_chk++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL timeout_idle: got busy=%b want 0", busy_o); end
      v0 = valid_hi;
      send_bits(WR, 27);
      idle(10);
      n_chk++; if (frame_o !== WR) begin n_err++; $display("FAIL timeout_next_frame: got %h want %h", frame_o, WR); end
      n_chk++; if (valid_hi - v0 != 1 || frm_tot - f0 != 1) begin n_err++;
         $display("FAIL timeout_next_clean: got valid=%0d ferr=%0d want 1 1", valid_hi - v0, frm_tot - f0); end
   endtask

   task automatic test_reset_midframe;
      int p0, f0, o0;
      ready = 1'b0;
      send_bits(RD, 27);
      idle(10);
      n_chk++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_valid: got %b want 1", valid_o); end
      send_bits(WR, 10);
      @(negedge clk) rst_ni = 1'b0;
      #1;
      n_chk++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin n_err++;
         $display("FAIL rstmid_outputs: valid=%b busy=%b want 0 0", valid_o, busy_o); end
      n_chk++; if (frame_o !== 27'h0) begin n_err++; $display("FAIL rstmid_frame: got %h want 0", frame_o); end
      sdata = 1'b0;
      idle(3);
      p0 = par_tot; f0 = frm_tot; o0 = ovr_tot;
      par_base = par_tot; frm_base = frm_tot; ovr_base = ovr_tot;
      rst_ni = 1'b1;
      idle(150);
      n_chk++; if (par_tot + frm_tot + ovr_tot - p0 - f0 - o0 != 0 || busy_o !== 1'b0) begin n_err++;
         $display("FAIL rstmid_no_errs: got %0d pulses busy=%b want 0 0", par_tot + frm_tot + ovr_tot - p0 - f0 - o0, busy_o); end
   endtask

   task automatic test_backpressure;
      int o0;
      ready = 1'b0;
      o0 = ovr_tot;
      send_bits(WR, 27);
      idle(10);
      n_chk++; if (valid_o !== 1'b1 || frame_o !== WR) begin n_err++;
         $display("FAIL bp_first_held: valid=%b frame=%h want 1 %h", valid_o, frame_o, WR); end
      send_bits(RD, 27);
      idle(10);
      n_chk++; if (ovr_tot - o0 != 1) begin n_err++; $display("FAIL bp_overrun: got %0d want 1", ovr_tot - o0); end
      n_chk++; if (frame_o !== WR || valid_o !== 1'b1) begin n_err++;
         $display("FAIL bp_frame_kept: valid=%b frame=%h want 1 %h", valid_o, frame_o, WR); end
      @(negedge clk) ready = 1'b1;
      @(negedge clk) ready = 1'b0;
      n_chk++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL bp_consume: got valid=%b want 0", valid_o); end
      n_chk++; if (frame_o !== WR) begin n_err++; $display("FAIL bp_frame_after: got %h want %h", frame_o, WR); end
   endtask

   task automatic test_back_to_back;
      int o0;
      ready = 1'b0;
      send_bits(RD, 27);
      idle(10);
      o0 = ovr_tot;
      send_bits(WR, 26);
      raise_stop(WR[0]);
      repeat (LAT - 1) @(posedge clk);
      @(negedge clk) ready = 1'b1;
      @(negedge clk) ready = 1'b0;
      idle(SCLK_DIV);
      sclk = 1'b0;
      idle(10);
      n_chk++; if (frame_o !== WR || valid_o !== 1'b1) begin n_err++;
         $display("FAIL b2b_frame: valid=%b frame=%h want 1 %h", valid_o, frame_o, WR); end
      n_chk++; if (ovr_tot - o0 != 0) begin n_err++; $display("FAIL b2b_no_overrun: got %0d want 0", ovr_tot - o0); end
      @(negedge clk) ready = 1'b1;
      idle(2);
   endtask

   task automatic test_counters;
`ifdef DESER_ERR_CNT_EN
      n_chk++; if (par_cnt != 16'(par_tot - par_base)) begin n_err++;
         $display("FAIL cnt_parity: got %0d want %0d", par_cnt, par_tot - par_base); end
      n_chk++; if (frm_cnt != 16'(frm_tot - frm_base)) begin n_err++;
         $display("FAIL cnt_frame: got %0d want %0d", frm_cnt, frm_tot - frm_base); end
      n_chk++; if (ovr_cnt != 16'(ovr_tot - ovr_base) || ovr_cnt != 16'd1) begin n_err++;
         $display("FAIL cnt_overrun: got %0d want %0d", ovr_cnt, ovr_tot - ovr_base); end
`endif
   endtask

   initial begin
      test_reset;
      test_write;
      test_read;
      test_parity_err;
      test_stop_err;
      test_timeout;
      test_reset_midframe;
      test_backpressure;
      test_back_to_back;
      test_counters;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
